// File: rtl/reset_sequencer.sv
// Staggered reset sequencer: holds all channels in reset, then releases them one by one.
// Optional watchdog retrigger enabled by defining RST_WATCHDOG_EN.
module reset_sequencer #(
    parameter int NUM_CH         = 3,
    parameter int HOLD_CYCLES    = 16,
    parameter int STAGGER_CYCLES = 8,
    parameter int WDT_CYCLES     = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              hit_reset,
`ifdef RST_WATCHDOG_EN
    input  logic              wdt_kick,
    output logic              wdt_fired,
`endif
    output logic [NUM_CH-1:0] reset_n_out,
    output logic              busy,
    output logic              all_released,
    output logic [1:0]        reset_cause
);

    localparam int MAX_HS  = (HOLD_CYCLES > STAGGER_CYCLES) ? HOLD_CYCLES : STAGGER_CYCLES;
    localparam int MAX_ALL = (MAX_HS > WDT_CYCLES) ? MAX_HS : WDT_CYCLES;
    localparam int CW      = $clog2(MAX_ALL + 1);
    localparam int IW      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    localparam logic [CW-1:0] HOLD_LAST    = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] STAGGER_LAST = CW'(STAGGER_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST     = IW'(NUM_CH - 1);

    localparam logic [1:0] CAUSE_POR = 2'b01;
    localparam logic [1:0] CAUSE_SW  = 2'b10;

    typedef enum logic [1:0] {
        ASSERT,
        RELEASE,
        RUN
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [NUM_CH-1:0] rst_n_d;
    logic              busy_d;
    logic              all_d;
    logic [1:0]        cause_d;
    logic              trigger;

`ifdef RST_WATCHDOG_EN
    localparam logic [CW-1:0] WDT_LAST  = CW'(WDT_CYCLES - 1);
    localparam logic [1:0]    CAUSE_WDT = 2'b11;

    logic [CW-1:0] wdt_cnt_q, wdt_cnt_d;
    logic          wdt_expire;
    logic          fired_d;

    // Watchdog only counts while the system is running; a kick wins over expiry.
    always_comb begin
        wdt_cnt_d  = '0;
        wdt_expire = 1'b0;
        if (state_q == RUN) begin
            if (wdt_kick) begin
                wdt_cnt_d = '0;
            end else if (wdt_cnt_q == WDT_LAST) begin
                wdt_expire = 1'b1;
            end else begin
                wdt_cnt_d = wdt_cnt_q + CW'(1);
            end
        end
        if (hit_reset) begin
            wdt_cnt_d = '0;
        end
        fired_d = wdt_expire & ~hit_reset;
    end

    assign trigger = hit_reset | wdt_expire;
`else
    assign trigger = hit_reset;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        rst_n_d = reset_n_out;
        busy_d  = busy;
        all_d   = all_released;
        cause_d = reset_cause;

        case (state_q)
            ASSERT: begin
                if (cnt_q == HOLD_LAST) begin
                    rst_n_d[0] = 1'b1;
                    cnt_d      = '0;
                    idx_d      = IW'(1);
                    if (NUM_CH == 1) begin
                        state_d = RUN;
                        busy_d  = 1'b0;
                        all_d   = 1'b1;
                    end else begin
                        state_d = RELEASE;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RELEASE: begin
                if (cnt_q == STAGGER_LAST) begin
                    rst_n_d[idx_q] = 1'b1;
                    cnt_d          = '0;
                    if (idx_q == IDX_LAST) begin
                        state_d = RUN;
                        busy_d  = 1'b0;
                        all_d   = 1'b1;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RUN: begin
                state_d = RUN;
            end
            default: begin
                state_d = ASSERT;
            end
        endcase

        // A trigger overrides everything and keeps the hold counter pinned at zero.
        if (trigger) begin
            state_d = ASSERT;
            cnt_d   = '0;
            idx_d   = '0;
            rst_n_d = '0;
            busy_d  = 1'b1;
            all_d   = 1'b0;
`ifdef RST_WATCHDOG_EN
            cause_d = hit_reset ? CAUSE_SW : CAUSE_WDT;
`else
            cause_d = CAUSE_SW;
`endif
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ASSERT;
            cnt_q        <= '0;
            idx_q        <= '0;
            reset_n_out  <= '0;
            busy         <= 1'b1;
            all_released <= 1'b0;
            reset_cause  <= CAUSE_POR;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            reset_n_out  <= rst_n_d;
            busy         <= busy_d;
            all_released <= all_d;
            reset_cause  <= cause_d;
        end
    end

`ifdef RST_WATCHDOG_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wdt_cnt_q <= '0;
            wdt_fired <= 1'b0;
        end else begin
            wdt_cnt_q <= wdt_cnt_d;
            wdt_fired <= fired_d;
        end
    end
`endif

endmodule
